// File: rtl/tinyqv_instr_aligner_if.sv
// rtl/tinyqv_instr_aligner_if.sv - fetch/decode handshake bundle for the instruction aligner
interface tinyqv_instr_aligner_if #(
    parameter int DEPTH   = 4,
    parameter int PC_BITS = 24
);
    localparam int LW = $clog2(DEPTH + 1);

    logic               flush;
    logic [PC_BITS-2:0] flush_pc;
    logic [15:0]        fetch_data;
    logic               fetch_valid;
    logic               fetch_ready;
    logic [31:0]        instr;
    logic               instr_valid;
    logic [1:0]         instr_len;
    logic               instr_ready;
    logic [PC_BITS-2:0] pc;
    logic [LW-1:0]      level;

    // Fetch unit and decoder side
    modport master (
        output flush, flush_pc, fetch_data, fetch_valid, instr_ready,
        input  fetch_ready, instr, instr_valid, instr_len, pc, level
    );

    // Aligner side
    modport slave (
        input  flush, flush_pc, fetch_data, fetch_valid, instr_ready,
        output fetch_ready, instr, instr_valid, instr_len, pc, level
    );
endinterface

// File: rtl/tinyqv_instr_aligner.sv
// rtl/tinyqv_instr_aligner.sv - halfword buffer presenting aligned 16/32-bit instructions
module tinyqv_instr_aligner #(
    parameter int DEPTH   = 4,
    parameter int PC_BITS = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    tinyqv_instr_aligner_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [15:0]        mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [PW-1:0]      head_p1;
    logic [LW-1:0]      level;
    logic [PC_BITS-2:0] pc_q;

    logic [15:0]        hw0;
    logic [15:0]        hw1;
    logic [1:0]         len;
    logic               valid;
    logic               ready;
    logic               push;
    logic               pop;
    logic [1:0]         pop_cnt;

    // Window, length decode and handshakes; everything derives from registered state,
    // the level gating hides stale entries left behind by pops and flushes.
    always_comb begin
        head_p1 = head + PW'(1);
        hw0     = 16'h0000;
        hw1     = 16'h0000;
        if (level >= LW'(1)) hw0 = mem[head];
        if (level >= LW'(2)) hw1 = mem[head_p1];
        len     = (hw0[1:0] == 2'b11) ? 2'b10 : 2'b01;
        valid   = ((level >= LW'(1)) && (hw0[1:0] != 2'b11)) || (level >= LW'(2));
        ready   = (level < LW'(DEPTH));
        push    = bus.fetch_valid && ready && !bus.flush;
        pop     = valid && bus.instr_ready && !bus.flush;
        pop_cnt = pop ? len : 2'b00;
    end

    assign bus.fetch_ready = ready;
    assign bus.instr       = {hw1, hw0};
    assign bus.instr_valid = valid;
    assign bus.instr_len   = len;
    assign bus.pc          = pc_q;
    assign bus.level       = level;

    // Buffer, pointers, occupancy and pc; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
            head  <= '0;
            tail  <= '0;
            level <= '0;
            pc_q  <= '0;
        end else if (bus.flush) begin
            tail  <= head;
            level <= '0;
            pc_q  <= bus.flush_pc;
        end else begin
            if (push) begin
                mem[tail] <= bus.fetch_data;
                tail      <= tail + PW'(1);
            end
            level <= level + LW'(push) - LW'(pop_cnt);
            head  <= head + PW'(pop_cnt);
            pc_q  <= pc_q + (PC_BITS-1)'(pop_cnt);
        end
    end
endmodule
